// File: rtl/mem_ctrl.sv
// Memory-access stage: runs loads/stores as multi-cycle SRAM or memory-mapped UART
// transactions, stalling the pipeline until the access completes.
module mem_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rMem_i,
  input  logic        wMem_i,
  input  logic [15:0] memAddr_i,
  input  logic [15:0] wData_i,
  input  logic        wReg_i,
  input  logic [3:0]  wRegAddr_i,
  output logic        stall_o,
  output logic [15:0] wData_o,
  output logic        wReg_o,
  output logic [3:0]  wRegAddr_o,
  output logic [17:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  typedef enum logic [3:0] {
    StIdle, StRd, StWrSetup, StWrPulse, StWrHold, StURd1, StURd2, StUWr1, StUWr2, StDone
  } state_e;

  state_e      state_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        wreg_q;
  logic [3:0]  wreg_addr_q;
  logic        is_load_q;
  logic        drive_q;
  logic        req;

  assign req      = rMem_i | wMem_i;
  assign ram_data = drive_q ? wdata_q : 16'hzzzz;

  // Strobes are set on the edge entering the state that needs them, so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      wreg_q      <= 1'b0;
      wreg_addr_q <= 4'h0;
      is_load_q   <= 1'b0;
      drive_q     <= 1'b0;
      ram_addr    <= 18'h0;
      ram_en_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      uart_rdn    <= 1'b1;
      uart_wrn    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            ram_addr    <= {2'b00, memAddr_i};
            wdata_q     <= wData_i;
            wreg_q      <= wReg_i;
            wreg_addr_q <= wRegAddr_i;
            is_load_q   <= ~wMem_i;
            if (memAddr_i == UART_STAT_ADDR) begin
              if (!wMem_i) rdata_q <= {14'b0, uart_data_ready, uart_tbre & uart_tsre};
              state_q <= StDone;
            end else if (memAddr_i == UART_DATA_ADDR) begin
              if (wMem_i) begin
                uart_wrn <= 1'b0;
                drive_q  <= 1'b1;
                state_q  <= StUWr1;
              end else begin
                uart_rdn <= 1'b0;
                state_q  <= StURd1;
              end
            end else if (wMem_i) begin
              ram_en_n <= 1'b0;
              drive_q  <= 1'b1;
              state_q  <= StWrSetup;
            end else begin
              ram_en_n <= 1'b0;
              ram_oe_n <= 1'b0;
              state_q  <= StRd;
            end
          end
        end
        StRd: begin
          rdata_q  <= ram_data;
          ram_en_n <= 1'b1;
          ram_oe_n <= 1'b1;
          state_q  <= StDone;
        end
        StWrSetup: begin
          ram_we_n <= 1'b0;
          state_q  <= StWrPulse;
        end
        StWrPulse: begin
          ram_we_n <= 1'b1;
          state_q  <= StWrHold;
        end
        StWrHold: begin
          ram_en_n <= 1'b1;
          drive_q  <= 1'b0;
          state_q  <= StDone;
        end
        StURd1: state_q <= StURd2;
        StURd2: begin
          rdata_q  <= ram_data;
          uart_rdn <= 1'b1;
          state_q  <= StDone;
        end
        StUWr1: begin
          uart_wrn <= 1'b1;
          state_q  <= StUWr2;
        end
        StUWr2: begin
          drive_q <= 1'b0;
          state_q <= StDone;
        end
        // Upstream still presents the finished request here; never re-accept it.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stall_o    = 1'b0;
    wData_o    = wData_i;
    wReg_o     = wReg_i;
    wRegAddr_o = wRegAddr_i;
    if (state_q == StIdle) begin
      stall_o = req & ~rst;
    end else begin
      stall_o    = (state_q != StDone) & ~rst;
      wData_o    = is_load_q ? rdata_q : wdata_q;
      wReg_o     = wreg_q;
      wRegAddr_o = wreg_addr_q;
    end
  end

endmodule
